// File: rtl/layer_mem_sequencer_pkg.sv
// Shared definitions for the layer memory sequencer: FSM encoding, index width helper
// and the macro that picks channel idx out of a flattened per-channel bus.
`ifndef LAYER_MEM_SEQUENCER_PKG_SV
`define LAYER_MEM_SEQUENCER_PKG_SV

`define LMS_SLICE(bus, idx, w) bus[(idx)*(w) +: (w)]

package layer_mem_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_RUN   = 2'd2,
    ST_FIN   = 2'd3
  } seq_state_t;

  // Width of the active-channel index; a single channel still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`endif

// File: rtl/layer_mem_sequencer_mem_port_arb.sv
// Grant and conflict logic for the single active channel, plus the registered memory port.
// A write whose select differs from a concurrent read is stalled; the read always wins.
module layer_mem_sequencer_mem_port_arb #(
  parameter int AW = 12,
  parameter int DW = 20,
  parameter int SW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          rd_req,
  input  logic          wr_req,
  input  logic [AW-1:0] rd_addr,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [SW-1:0] rd_sel,
  input  logic [SW-1:0] wr_sel,
  output logic          rd_gnt,
  output logic          wr_gnt,
  output logic          cwr,
  output logic [AW-1:0] caddr_wr,
  output logic [DW-1:0] cdata_wr,
  output logic          crd,
  output logic [AW-1:0] caddr_rd,
  output logic [SW-1:0] csel
);

  logic          cwr_reg;
  logic          crd_reg;
  logic [AW-1:0] caddr_wr_reg;
  logic [DW-1:0] cdata_wr_reg;
  logic [AW-1:0] caddr_rd_reg;
  logic [SW-1:0] csel_reg;

  assign rd_gnt = en & rd_req;
  assign wr_gnt = en & wr_req & (~rd_req | (rd_sel == wr_sel));

  always_ff @(posedge clk) begin
    if (reset) begin
      cwr_reg      <= 1'b0;
      crd_reg      <= 1'b0;
      caddr_wr_reg <= '0;
      cdata_wr_reg <= '0;
      caddr_rd_reg <= '0;
      csel_reg     <= '0;
    end else begin
      cwr_reg <= wr_gnt;
      crd_reg <= rd_gnt;
      if (wr_gnt) begin
        caddr_wr_reg <= wr_addr;
        cdata_wr_reg <= wr_data;
      end
      if (rd_gnt) begin
        caddr_rd_reg <= rd_addr;
      end
      // Read select has priority; it equals wr_sel anyway when both are granted.
      if (rd_gnt) begin
        csel_reg <= rd_sel;
      end else if (wr_gnt) begin
        csel_reg <= wr_sel;
      end
    end
  end

  assign cwr      = cwr_reg;
  assign crd      = crd_reg;
  assign caddr_wr = caddr_wr_reg;
  assign cdata_wr = cdata_wr_reg;
  assign caddr_rd = caddr_rd_reg;
  assign csel     = csel_reg;

endmodule

// File: rtl/layer_mem_sequencer.sv
// Starts NCH compute layers in order, gives the running layer the shared memory port,
// and records sticky errors for requests or done pulses from channels that are not running.
module layer_mem_sequencer
  import layer_mem_sequencer_pkg::*;
#(
  parameter int NCH = 3,
  parameter int AW  = 12,
  parameter int DW  = 20,
  parameter int SW  = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ready,
  output logic              busy,
  output logic [NCH-1:0]    ch_start,
  input  logic [NCH-1:0]    ch_done,
  input  logic [NCH-1:0]    wr_req,
  input  logic [NCH*AW-1:0] wr_addr,
  input  logic [NCH*DW-1:0] wr_data,
  input  logic [NCH*SW-1:0] wr_sel,
  input  logic [NCH-1:0]    rd_req,
  input  logic [NCH*AW-1:0] rd_addr,
  input  logic [NCH*SW-1:0] rd_sel,
  output logic [NCH-1:0]    wr_gnt,
  output logic [NCH-1:0]    rd_gnt,
  output logic              cwr,
  output logic [AW-1:0]     caddr_wr,
  output logic [DW-1:0]     cdata_wr,
  output logic              crd,
  output logic [AW-1:0]     caddr_rd,
  output logic [SW-1:0]     csel,
  output logic [1:0]        err
);

  localparam int KW = idx_width(NCH);

  seq_state_t     state_reg;
  logic [KW-1:0]  k_reg;
  logic           busy_reg;
  logic [NCH-1:0] ch_start_reg;
  logic [1:0]     err_reg;

  logic [NCH-1:0] k_onehot;
  logic [NCH-1:0] active_mask;
  logic           run_active;
  logic           done_k;
  logic           req_stray;
  logic           done_stray;

  logic           sel_rd_req;
  logic           sel_wr_req;
  logic [AW-1:0]  sel_rd_addr;
  logic [AW-1:0]  sel_wr_addr;
  logic [DW-1:0]  sel_wr_data;
  logic [SW-1:0]  sel_rd_sel;
  logic [SW-1:0]  sel_wr_sel;
  logic           gnt_rd;
  logic           gnt_wr;

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_onehot
      assign k_onehot[gi] = (k_reg == KW'(gi));
    end
  endgenerate

  assign run_active  = (state_reg == ST_RUN);
  assign active_mask = run_active ? k_onehot : '0;
  assign done_k      = |(ch_done & k_onehot);
  assign req_stray   = |((rd_req | wr_req) & ~active_mask);
  assign done_stray  = |(ch_done & ~active_mask);

  // Route the active channel's request fields to the arbiter.
  always_comb begin
    sel_rd_req  = 1'b0;
    sel_wr_req  = 1'b0;
    sel_rd_addr = '0;
    sel_wr_addr = '0;
    sel_wr_data = '0;
    sel_rd_sel  = '0;
    sel_wr_sel  = '0;
    for (int i = 0; i < NCH; i++) begin
      if (k_onehot[i]) begin
        sel_rd_req  = rd_req[i];
        sel_wr_req  = wr_req[i];
        sel_rd_addr = `LMS_SLICE(rd_addr, i, AW);
        sel_wr_addr = `LMS_SLICE(wr_addr, i, AW);
        sel_wr_data = `LMS_SLICE(wr_data, i, DW);
        sel_rd_sel  = `LMS_SLICE(rd_sel, i, SW);
        sel_wr_sel  = `LMS_SLICE(wr_sel, i, SW);
      end
    end
  end

  layer_mem_sequencer_mem_port_arb #(
    .AW(AW),
    .DW(DW),
    .SW(SW)
  ) u_arb (
    .clk      (clk),
    .reset    (reset),
    .en       (run_active),
    .rd_req   (sel_rd_req),
    .wr_req   (sel_wr_req),
    .rd_addr  (sel_rd_addr),
    .wr_addr  (sel_wr_addr),
    .wr_data  (sel_wr_data),
    .rd_sel   (sel_rd_sel),
    .wr_sel   (sel_wr_sel),
    .rd_gnt   (gnt_rd),
    .wr_gnt   (gnt_wr),
    .cwr      (cwr),
    .caddr_wr (caddr_wr),
    .cdata_wr (cdata_wr),
    .crd      (crd),
    .caddr_rd (caddr_rd),
    .csel     (csel)
  );

  assign rd_gnt = gnt_rd ? k_onehot : '0;
  assign wr_gnt = gnt_wr ? k_onehot : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      k_reg        <= '0;
      busy_reg     <= 1'b0;
      ch_start_reg <= '0;
      err_reg      <= 2'b00;
    end else begin
      ch_start_reg <= '0;
      err_reg      <= err_reg | {done_stray, req_stray};
      case (state_reg)
        ST_IDLE: begin
          if (ready) begin
            state_reg    <= ST_START;
            k_reg        <= '0;
            busy_reg     <= 1'b1;
            ch_start_reg <= NCH'(1);
          end
        end
        ST_START: begin
          state_reg <= ST_RUN;
        end
        ST_RUN: begin
          if (done_k) begin
            if (k_reg == KW'(NCH - 1)) begin
              state_reg <= ST_FIN;
            end else begin
              // The start pulse for the next layer is issued together with entering START.
              k_reg        <= k_reg + KW'(1);
              state_reg    <= ST_START;
              ch_start_reg <= k_onehot << 1;
            end
          end
        end
        ST_FIN: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy     = busy_reg;
  assign ch_start = ch_start_reg;
  assign err      = err_reg;

endmodule

// File: tb/tb_layer_mem_sequencer.sv
// Directed bench for layer_mem_sequencer: a cycle model of the layer sequence and memory port
// is compared on every falling edge, and literal expectations pin the key scenarios.
module tb_layer_mem_sequencer;

  localparam int NCH = 3;
  localparam int AW  = 12;
  localparam int DW  = 20;
  localparam int SW  = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              ready;
  logic              busy;
  logic [NCH-1:0]    ch_start;
  logic [NCH-1:0]    ch_done;
  logic [NCH-1:0]    wr_req;
  logic [NCH*AW-1:0] wr_addr;
  logic [NCH*DW-1:0] wr_data;
  logic [NCH*SW-1:0] wr_sel;
  logic [NCH-1:0]    rd_req;
  logic [NCH*AW-1:0] rd_addr;
  logic [NCH*SW-1:0] rd_sel;
  logic [NCH-1:0]    wr_gnt;
  logic [NCH-1:0]    rd_gnt;
  logic              cwr;
  logic [AW-1:0]     caddr_wr;
  logic [DW-1:0]     cdata_wr;
  logic              crd;
  logic [AW-1:0]     caddr_rd;
  logic [SW-1:0]     csel;
  logic [1:0]        err;

  always #5 clk = ~clk;

  layer_mem_sequencer #(.NCH(NCH), .AW(AW), .DW(DW), .SW(SW)) dut (
    .clk(clk), .reset(reset), .ready(ready), .busy(busy), .ch_start(ch_start),
    .ch_done(ch_done), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_sel(wr_sel), .rd_req(rd_req), .rd_addr(rd_addr), .rd_sel(rd_sel),
    .wr_gnt(wr_gnt), .rd_gnt(rd_gnt), .cwr(cwr), .caddr_wr(caddr_wr),
    .cdata_wr(cdata_wr), .crd(crd), .caddr_rd(caddr_rd), .csel(csel), .err(err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: which layer is running (-1 none), whether its start pulse went out,
  // and the one-cycle tail after the last layer completes.
  int            m_layer   = -1;
  bit            m_started = 1'b0;
  bit            m_tail    = 1'b0;
  bit            m_live    = 1'b0;
  bit            m_cwr, m_crd;
  logic [AW-1:0] m_caw, m_car;
  logic [DW-1:0] m_cdw;
  logic [SW-1:0] m_csel;
  logic [1:0]    m_err;

  function automatic bit m_run();
    return (m_layer >= 0) && m_started;
  endfunction

  function automatic logic [NCH-1:0] exp_rd_gnt();
    logic [NCH-1:0] g = '0;
    if (m_run() && rd_req[m_layer]) g[m_layer] = 1'b1;
    return g;
  endfunction

  function automatic logic [NCH-1:0] exp_wr_gnt();
    logic [NCH-1:0] g = '0;
    if (m_run() && wr_req[m_layer] &&
        (!rd_req[m_layer] || rd_sel[m_layer*SW +: SW] == wr_sel[m_layer*SW +: SW]))
      g[m_layer] = 1'b1;
    return g;
  endfunction

  function automatic logic [NCH-1:0] exp_start();
    logic [NCH-1:0] s = '0;
    if (m_layer >= 0 && !m_started) s[m_layer] = 1'b1;
    return s;
  endfunction

  always @(posedge clk) begin
    logic [NCH-1:0] g_rd;
    logic [NCH-1:0] g_wr;
    logic [NCH-1:0] mask;
    if (reset) begin
      m_layer = -1; m_started = 1'b0; m_tail = 1'b0;
      m_cwr = 1'b0; m_crd = 1'b0; m_caw = '0; m_car = '0; m_cdw = '0; m_csel = '0;
      m_err = 2'b00; m_live = 1'b1;
    end else if (m_live) begin
      g_rd = exp_rd_gnt();
      g_wr = exp_wr_gnt();
      mask = '0;
      if (m_run()) mask[m_layer] = 1'b1;
      if (|((rd_req | wr_req) & ~mask)) m_err[0] = 1'b1;
      if (|(ch_done & ~mask)) m_err[1] = 1'b1;
      m_cwr = |g_wr;
      m_crd = |g_rd;
      if (m_cwr) begin
        m_caw = wr_addr[m_layer*AW +: AW];
        m_cdw = wr_data[m_layer*DW +: DW];
      end
      if (m_crd) m_car = rd_addr[m_layer*AW +: AW];
      if (m_crd) m_csel = rd_sel[m_layer*SW +: SW];
      else if (m_cwr) m_csel = wr_sel[m_layer*SW +: SW];
      if (m_tail) begin
        m_tail = 1'b0;
      end else if (m_layer < 0) begin
        if (ready) begin m_layer = 0; m_started = 1'b0; end
      end else if (!m_started) begin
        m_started = 1'b1;
      end else if (ch_done[m_layer]) begin
        if (m_layer == NCH - 1) begin m_layer = -1; m_tail = 1'b1; end
        else begin m_layer = m_layer + 1; m_started = 1'b0; end
      end
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      check("cmp_busy", busy, ((m_layer >= 0) || m_tail) ? 1 : 0);
      check("cmp_ch_start", ch_start, exp_start());
      check("cmp_rd_gnt", rd_gnt, exp_rd_gnt());
      check("cmp_wr_gnt", wr_gnt, exp_wr_gnt());
      check("cmp_cwr", cwr, m_cwr);
      check("cmp_crd", crd, m_crd);
      check("cmp_caddr_wr", caddr_wr, m_caw);
      check("cmp_cdata_wr", cdata_wr, m_cdw);
      check("cmp_caddr_rd", caddr_rd, m_car);
      check("cmp_csel", csel, m_csel);
      check("cmp_err", err, m_err);
      if (cwr) $display("mem write addr=0x%03h data=0x%05h sel=%0d", caddr_wr, cdata_wr, csel);
      if (crd) $display("mem read  addr=0x%03h sel=%0d", caddr_rd, csel);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ready = 1'b0; ch_done = '0; wr_req = '0; rd_req = '0;
    wr_addr = '0; wr_data = '0; wr_sel = '0; rd_addr = '0; rd_sel = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the end, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    clear_inputs();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    check("rst_busy", busy, 0); check("rst_start", ch_start, 0);
    check("rst_err", err, 0); check("rst_cwr", cwr, 0); check("rst_csel", csel, 0);
    tick();

    // Basic sequence through all three layers
    ready = 1'b1;
    @(negedge clk); check("idle_busy", busy, 0);
    tick();
    ready = 1'b0;
    @(negedge clk); check("seq_busy", busy, 1); check("seq_start0", ch_start, 3'b001);
    tick();
    ch_done = 3'b001;
    @(negedge clk); check("run0_start", ch_start, 3'b000);
    tick();
    ch_done = '0;
    @(negedge clk); check("seq_start1", ch_start, 3'b010);
    tick();

    // Write path on layer 1
    wr_req = 3'b010; wr_addr[AW +: AW] = 12'h0A5; wr_data[DW +: DW] = 20'h12345; wr_sel[SW +: SW] = 3'd3;
    @(negedge clk); check("wr_gnt", wr_gnt, 3'b010); check("wr_rd_gnt", rd_gnt, 3'b000);
    tick();
    wr_req = '0;
    @(negedge clk);
    check("wr_cwr", cwr, 1); check("wr_caddr", caddr_wr, 12'h0A5);
    check("wr_cdata", cdata_wr, 20'h12345); check("wr_csel", csel, 3);
    tick();
    ch_done = 3'b010;
    @(negedge clk); check("wr_cwr_drop", cwr, 0);
    tick();
    ch_done = '0;
    @(negedge clk); check("seq_start2", ch_start, 3'b100);
    tick();

    // Select conflict on layer 2: read wins, write waits
    rd_req = 3'b100; wr_req = 3'b100;
    rd_sel[2*SW +: SW] = 3'd4; wr_sel[2*SW +: SW] = 3'd5;
    rd_addr[2*AW +: AW] = 12'h111; wr_addr[2*AW +: AW] = 12'h222; wr_data[2*DW +: DW] = 20'h0BEEF;
    @(negedge clk); check("cf_rd_gnt", rd_gnt, 3'b100); check("cf_wr_gnt", wr_gnt, 3'b000);
    tick();
    rd_req = '0;
    @(negedge clk);
    check("cf_crd", crd, 1); check("cf_csel_rd", csel, 4); check("cf_caddr_rd", caddr_rd, 12'h111);
    check("cf_cwr0", cwr, 0); check("cf_wr_gnt2", wr_gnt, 3'b100);
    tick();
    wr_req = '0;
    @(negedge clk);
    check("cf_cwr", cwr, 1); check("cf_csel_wr", csel, 5); check("cf_caddr_wr", caddr_wr, 12'h222);
    check("cf_crd0", crd, 0);
    tick();

    // Same select: both granted
    rd_req = 3'b100; wr_req = 3'b100;
    rd_sel[2*SW +: SW] = 3'd1; wr_sel[2*SW +: SW] = 3'd1;
    wr_addr[2*AW +: AW] = 12'h333; wr_data[2*DW +: DW] = 20'h54321;
    @(negedge clk); check("ss_rd_gnt", rd_gnt, 3'b100); check("ss_wr_gnt", wr_gnt, 3'b100);
    tick();

    // Read together with the last done: still granted, then the sequence ends
    wr_req = '0; rd_req = 3'b100; rd_sel[2*SW +: SW] = 3'd2; rd_addr[2*AW +: AW] = 12'h444;
    ch_done = 3'b100;
    @(negedge clk);
    check("ss_cwr", cwr, 1); check("ss_crd", crd, 1); check("ss_csel", csel, 1);
    check("ss_cdata", cdata_wr, 20'h54321); check("dn_rd_gnt", rd_gnt, 3'b100);
    tick();
    clear_inputs();
    @(negedge clk);
    check("fin_busy", busy, 1); check("dn_crd", crd, 1); check("dn_csel", csel, 2);
    check("dn_caddr_rd", caddr_rd, 12'h444);
    tick();
    @(negedge clk); check("end_busy", busy, 0); check("end_err", err, 2'b00);
    tick();

    // Protocol errors
    ready = 1'b1;
    @(negedge clk);
    tick();
    ready = 1'b0;
    @(negedge clk); check("e_start0", ch_start, 3'b001);
    tick();
    wr_req = 3'b100; wr_sel[2*SW +: SW] = 3'd6;
    @(negedge clk); check("e_wr_gnt", wr_gnt, 3'b000);
    tick();
    wr_req = '0; ch_done = 3'b010;
    @(negedge clk); check("e_cwr", cwr, 0); check("e_err01", err, 2'b01);
    tick();
    ch_done = '0;
    @(negedge clk); check("e_err11", err, 2'b11); check("e_busy", busy, 1); check("e_start", ch_start, 0);
    tick();
    ch_done = 3'b001;
    @(negedge clk);
    tick();
    ch_done = '0;
    @(negedge clk); check("e_start1", ch_start, 3'b010); check("e_err_sticky", err, 2'b11);
    tick();

    // Reset in the middle of layer 1 with requests pending
    rd_req = 3'b010; wr_req = 3'b010; rd_sel[SW +: SW] = 3'd2; wr_sel[SW +: SW] = 3'd7;
    reset = 1'b1;
    @(negedge clk); check("r_rd_gnt", rd_gnt, 3'b010);
    tick();
    reset = 1'b0; clear_inputs();
    @(negedge clk);
    check("r_busy", busy, 0); check("r_start", ch_start, 0); check("r_err", err, 0);
    check("r_cwr", cwr, 0); check("r_crd", crd, 0); check("r_csel", csel, 0); check("r_rd_gnt0", rd_gnt, 0);
    tick();

    // Restart with ready held high: a new sequence starts right after FIN
    ready = 1'b1;
    @(negedge clk);
    tick();
    @(negedge clk); check("h_start0", ch_start, 3'b001); check("h_busy", busy, 1);
    for (int i = 0; i < NCH; i++) begin
      tick();
      ch_done = '0; ch_done[i] = 1'b1;
      @(negedge clk);
      tick();
      ch_done = '0;
      @(negedge clk);
    end
    check("h_fin_busy", busy, 1);
    tick();
    @(negedge clk); check("h_idle_busy", busy, 0);
    tick();
    ready = 1'b0;
    @(negedge clk); check("h_restart", ch_start, 3'b001); check("h_err", err, 2'b00);
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
